// File: rtl/flac_pkg.sv
// Shared FLAC decoder definitions: FSM encoding, predictor-order type and limits.
package flac_pkg;

  localparam int MAX_FIXED_ORDER = 4;

  typedef logic [2:0] order_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_DECODE = 3'd2,
    ST_ERROR  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/fixed_predictor_calc.sv
// Combinational FLAC fixed-predictor polynomial (orders 0..4), h1 is the newest sample.
module fixed_predictor_calc
  import flac_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + 4
) (
  input  logic [SAMPLE_WIDTH-1:0] h1,
  input  logic [SAMPLE_WIDTH-1:0] h2,
  input  logic [SAMPLE_WIDTH-1:0] h3,
  input  logic [SAMPLE_WIDTH-1:0] h4,
  input  order_t                  order,
  output logic [ACC_WIDTH-1:0]    pred
);

  localparam int EXT = ACC_WIDTH - SAMPLE_WIDTH;

  logic [ACC_WIDTH-1:0] e1, e2, e3, e4;

  // Sign-extend once; all further arithmetic is modular in ACC_WIDTH.
  assign e1 = {{EXT{h1[SAMPLE_WIDTH-1]}}, h1};
  assign e2 = {{EXT{h2[SAMPLE_WIDTH-1]}}, h2};
  assign e3 = {{EXT{h3[SAMPLE_WIDTH-1]}}, h3};
  assign e4 = {{EXT{h4[SAMPLE_WIDTH-1]}}, h4};

  always_comb begin
    pred = '0;
    case (order)
      3'd1: pred = e1;
      3'd2: pred = (e1 << 1) - e2;
      3'd3: pred = (e1 << 1) + e1 - (e2 << 1) - e2 + e3;
      3'd4: pred = (e1 << 2) - (e2 << 2) - (e2 << 1) + (e3 << 2) - e4;
      default: pred = '0;
    endcase
  end

endmodule

// File: rtl/fixed_predictor_decoder.sv
// FLAC FIXED-subframe reconstruction: warm-up passthrough, then residual + prediction.
module fixed_predictor_decoder
  import flac_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int RES_WIDTH    = 24,
  parameter int BS_WIDTH     = 16,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + 4
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  input  logic                    iStart,
  input  logic [2:0]              iOrder,
  input  logic [BS_WIDTH-1:0]     iBlockSize,
  input  logic [RES_WIDTH-1:0]    iResidual,
  input  logic                    iResidualValid,
  output logic                    oResidualReady,
  output logic [SAMPLE_WIDTH-1:0] oSample,
  output logic                    oSampleValid,
  output logic                    oFrameDone,
  output logic                    oBusy,
  output logic                    oError,
  output logic [2:0]              oState
);

  // Handshake: a word moves when iResidualValid && oResidualReady && iEnable;
  // ready never depends on valid, and valid may be held or dropped freely.

  state_t                state, state_n;
  order_t                order_q;
  logic [BS_WIDTH-1:0]   bs_q, cnt, cnt_inc;
  logic [SAMPLE_WIDTH-1:0] h1, h2, h3, h4;
  logic [SAMPLE_WIDTH-1:0] sample_q, res_s, out_val;
  logic                  sample_valid_q, frame_done_q, busy_q, error_q;
  logic [ACC_WIDTH-1:0]  pred;
  logic                  xfer;
  logic                  unused_bits;

  fixed_predictor_calc #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_calc (
    .h1   (h1),
    .h2   (h2),
    .h3   (h3),
    .h4   (h4),
    .order(order_q),
    .pred (pred)
  );

  // Output wraps to SAMPLE_WIDTH, so only the low bits of residual and prediction matter.
  assign res_s       = iResidual[SAMPLE_WIDTH-1:0];
  assign unused_bits = ^{iResidual[RES_WIDTH-1:SAMPLE_WIDTH], pred[ACC_WIDTH-1:SAMPLE_WIDTH]};

  assign oResidualReady = iEnable && ((state == ST_WARMUP) || (state == ST_DECODE));
  assign xfer           = iResidualValid && oResidualReady;
  assign cnt_inc        = cnt + BS_WIDTH'(1);
  assign out_val        = (state == ST_DECODE) ? (res_s + pred[SAMPLE_WIDTH-1:0]) : res_s;

  always_ff @(posedge iClock) begin
    if (!iReset) state <= ST_IDLE;
    else if (iEnable) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          if (iOrder > order_t'(MAX_FIXED_ORDER)) state_n = ST_ERROR;
          else if (iBlockSize == '0)              state_n = ST_DONE;
          else if (iOrder == 3'd0)                state_n = ST_DECODE;
          else                                    state_n = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (xfer) begin
          if (cnt_inc == bs_q)                         state_n = ST_DONE;
          else if (cnt_inc == BS_WIDTH'(order_q))      state_n = ST_DECODE;
        end
      end
      ST_DECODE: if (xfer && (cnt_inc == bs_q)) state_n = ST_DONE;
      ST_ERROR:  state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      order_q        <= '0;
      bs_q           <= '0;
      cnt            <= '0;
      h1             <= '0;
      h2             <= '0;
      h3             <= '0;
      h4             <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else if (iEnable) begin
      sample_valid_q <= xfer;
      frame_done_q   <= (state == ST_DONE);
      if (xfer) begin
        sample_q <= out_val;
        h4       <= h3;
        h3       <= h2;
        h2       <= h1;
        h1       <= out_val;
        cnt      <= cnt_inc;
      end
      if ((state == ST_IDLE) && iStart) begin
        order_q <= iOrder;
        bs_q    <= iBlockSize;
        cnt     <= '0;
        busy_q  <= 1'b1;
        error_q <= 1'b0;
      end
      if (state == ST_ERROR) error_q <= 1'b1;
      if (state == ST_DONE)  busy_q  <= 1'b0;
    end
  end

  assign oSample      = sample_q;
  assign oSampleValid = sample_valid_q;
  assign oFrameDone   = frame_done_q;
  assign oBusy        = busy_q;
  assign oError       = error_q;
  assign oState       = state;

endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Directed, table-driven bench for fixed_predictor_decoder with a sample scoreboard.
module tb_fixed_predictor_decoder;

  logic        iClock = 1'b0;
  logic        iReset, iEnable, iStart, iResidualValid;
  logic [2:0]  iOrder;
  logic [15:0] iBlockSize;
  logic [23:0] iResidual;
  logic        oResidualReady, oSampleValid, oFrameDone, oBusy, oError;
  logic [15:0] oSample;
  logic [2:0]  oState;

  fixed_predictor_decoder dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iStart        (iStart),
    .iOrder        (iOrder),
    .iBlockSize    (iBlockSize),
    .iResidual     (iResidual),
    .iResidualValid(iResidualValid),
    .oResidualReady(oResidualReady),
    .oSample       (oSample),
    .oSampleValid  (oSampleValid),
    .oFrameDone    (oFrameDone),
    .oBusy         (oBusy),
    .oError        (oError),
    .oState        (oState)
  );

  // ---------------- clock / reset ----------------
  always #5 iClock = ~iClock;

  int   checks = 0, errors = 0;
  int   cyc = 0, done_count = 0, done_cyc = 0, last_sample_cyc = 0, start_cyc = 0;
  logic en_last = 1'b0;
  logic got_sample = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  typedef struct {
    int order;
    int bs;
    int n;
    int din[8];
    int dout[8];
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // An output is new only if the edge that produced it was an enabled, non-reset edge.
  always @(posedge iClock) begin
    cyc     <= cyc + 1;
    en_last <= iEnable && iReset;
  end

  always @(negedge iClock) begin
    if (en_last) begin
      if (oSampleValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0d expected none", oSample);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", {16'b0, oSample}, {16'b0, mon_e});
        end
        last_sample_cyc = cyc;
        got_sample      = 1'b1;
      end
      if (oFrameDone) begin
        done_count++;
        done_cyc = cyc;
        if (got_sample) check("done_latency", cyc - last_sample_cyc, 1);
        got_sample = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers run from the phase #1 after a rising edge.
  task automatic start_frame(input int order, input int bs);
    iStart     = 1'b1;
    iOrder     = order[2:0];
    iBlockSize = bs[15:0];
    @(posedge iClock); #1;
    iStart    = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", oBusy, 1);
  endtask

  task automatic send_word(input logic [23:0] data);
    logic ok;
    ok             = 1'b0;
    iResidual      = data;
    iResidualValid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge iClock);
      if (oResidualReady) ok = 1'b1;
      @(posedge iClock); #1;
    end
    iResidualValid = 1'b0;
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic stall_with_valid(input logic [23:0] data);
    iResidual      = data;
    iResidualValid = 1'b1;
    iEnable        = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge iClock);
      check("ready_gated_by_enable", oResidualReady, 0);
      @(posedge iClock); #1;
    end
    iEnable = 1'b1;
  endtask

  task automatic wait_done(input int start_cnt);
    for (int t = 0; t < 30 && done_count == start_cnt; t++) begin
      @(posedge iClock); #1;
    end
    check("frame_done_count", done_count - start_cnt, 1);
  endtask

  task automatic run_frame(input int vi, input bit toggle, input int stall_idx, input bit extra);
    int start_cnt;
    start_cnt = done_count;
    for (int i = 0; i < vecs[vi].n; i++) exp_q.push_back(16'(vecs[vi].dout[i]));
    start_frame(vecs[vi].order, vecs[vi].bs);
    for (int i = 0; i < vecs[vi].n; i++) begin
      if (toggle && i > 0) begin
        @(posedge iClock); #1;
      end
      if (i == stall_idx) stall_with_valid(24'(vecs[vi].din[i]));
      send_word(24'(vecs[vi].din[i]));
    end
    if (extra) begin
      iResidual      = 24'd99;
      iResidualValid = 1'b1;
    end
    wait_done(start_cnt);
    iResidualValid = 1'b0;
    check("all_samples_seen", exp_q.size(), 0);
    check("busy_after_done", oBusy, 0);
    if (vecs[vi].bs == 0) check("empty_done_delay", done_cyc - start_cyc, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int  start_cnt;
    logic ready_seen;

    vecs[0] = '{order: 2, bs: 5, n: 5, din: '{10, 20, 1, -2, 0, 0, 0, 0},
                dout: '{10, 20, 31, 40, 49, 0, 0, 0}};
    vecs[1] = '{order: 3, bs: 4, n: 4, din: '{1, 2, 4, 0, 0, 0, 0, 0},
                dout: '{1, 2, 4, 7, 0, 0, 0, 0}};
    vecs[2] = '{order: 4, bs: 5, n: 5, din: '{1, 2, 4, 8, 0, 0, 0, 0},
                dout: '{1, 2, 4, 8, 15, 0, 0, 0}};
    vecs[3] = '{order: 1, bs: 2, n: 2, din: '{32767, 1, 0, 0, 0, 0, 0, 0},
                dout: '{32767, -32768, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{order: 4, bs: 3, n: 3, din: '{5, 6, 7, 0, 0, 0, 0, 0},
                dout: '{5, 6, 7, 0, 0, 0, 0, 0}};
    vecs[5] = '{order: 0, bs: 2, n: 2, din: '{-3, 9, 0, 0, 0, 0, 0, 0},
                dout: '{-3, 9, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{order: 0, bs: 0, n: 0, din: '{0, 0, 0, 0, 0, 0, 0, 0},
                dout: '{0, 0, 0, 0, 0, 0, 0, 0}};

    iReset = 1'b0; iEnable = 1'b0; iStart = 1'b0; iOrder = '0;
    iBlockSize = '0; iResidual = '0; iResidualValid = 1'b0;
    repeat (3) @(posedge iClock);
    #1;
    check("rst_sample", oSample, 0);
    check("rst_sample_valid", oSampleValid, 0);
    check("rst_frame_done", oFrameDone, 0);
    check("rst_busy", oBusy, 0);
    check("rst_error", oError, 0);
    check("rst_ready", oResidualReady, 0);
    iReset  = 1'b1;
    iEnable = 1'b1;
    @(posedge iClock); #1;

    for (int v = 0; v < 4; v++) run_frame(v, 1'b0, -1, 1'b0);
    run_frame(4, 1'b0, -1, 1'b1);   // a 4th word is offered but must not be taken
    run_frame(6, 1'b0, -1, 1'b0);   // empty block

    // Illegal order: error, done pulse, never ready.
    start_cnt      = done_count;
    ready_seen     = 1'b0;
    iResidual      = 24'd7;
    iResidualValid = 1'b1;
    start_frame(5, 4);
    for (int t = 0; t < 10 && done_count == start_cnt; t++) begin
      @(negedge iClock);
      if (oResidualReady) ready_seen = 1'b1;
      @(posedge iClock); #1;
    end
    iResidualValid = 1'b0;
    check("error_frame_done", done_count - start_cnt, 1);
    check("error_ready_never", ready_seen, 0);
    check("error_flag", oError, 1);
    check("error_busy_dropped", oBusy, 0);
    repeat (2) @(posedge iClock);
    #1;
    check("error_sticky", oError, 1);

    run_frame(5, 1'b0, -1, 1'b0);
    check("error_cleared", oError, 0);

    // Same data as the first frame, with valid gaps and an enable stall.
    run_frame(0, 1'b1, 3, 1'b0);

    // Reset after the third sample of an order-2 frame.
    start_cnt = done_count;
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd20);
    exp_q.push_back(16'd31);
    start_frame(2, 5);
    send_word(24'd10);
    send_word(24'd20);
    send_word(24'd1);
    @(negedge iClock);
    iReset = 1'b0;
    @(posedge iClock); #1;
    check("midrst_sample", oSample, 0);
    check("midrst_sample_valid", oSampleValid, 0);
    check("midrst_frame_done", oFrameDone, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_error", oError, 0);
    check("midrst_ready", oResidualReady, 0);
    check("midrst_state_idle", oState, 0);
    iReset     = 1'b1;
    got_sample = 1'b0;
    repeat (5) @(posedge iClock);
    #1;
    check("midrst_no_done", done_count - start_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
